prim_subreg_shadow_be: RTL

Shadowed, byte-enabled register slice for the register file: a parametrised successor of the single-write subreg. Software must write the same value twice before the committed value changes; every software write is byte-masked and access-mode transformed. Hardware update keeps its direct path, and an inverted shadow copy detects storage faults. Sits behind the register-interface decode; drives hardware consumers and read-back muxes.

---
 rtl/prim_subreg_pkg.sv | 32 +++
 rtl/prim_subreg_sw_xform.sv | 32 +++
 rtl/prim_subreg_shadow_be.sv | 116 +++++++++++
 3 files changed

// File: rtl/prim_subreg_pkg.sv
// rtl/prim_subreg_pkg.sv - shared types and helpers for register slices
package prim_subreg_pkg;

    typedef enum logic [2:0] {
        SW_RW  = 3'd0,
        SW_WO  = 3'd1,
        SW_RO  = 3'd2,
        SW_W1C = 3'd3,
        SW_W1S = 3'd4,
        SW_W0C = 3'd5
    } sw_access_e;

    typedef enum logic {
        PH_IDLE   = 1'b0,
        PH_STAGED = 1'b1
    } shadow_phase_e;

    localparam int MaxDw = 64;

    // Bit k of the result follows byte enable k/8; bits at or above dw are 0.
    function automatic logic [MaxDw-1:0] be2mask(input logic [7:0] be, input int dw);
        logic [MaxDw-1:0] m;
        m = '0;
        for (int i = 0; i < MaxDw; i++) begin
            if (i < dw) begin
                m[i] = be[i/8];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/prim_subreg_sw_xform.sv
// rtl/prim_subreg_sw_xform.sv - byte-masked software write transform
module prim_subreg_sw_xform
    import prim_subreg_pkg::*;
#(
    parameter int         DW       = 32,
    parameter sw_access_e SwAccess = SW_RW,
    localparam int        BEW      = (DW + 7) / 8
) (
    input  logic [DW-1:0]  q,
    input  logic [DW-1:0]  wd,
    input  logic [BEW-1:0] be,
    output logic [DW-1:0]  t
);

    logic [MaxDw-1:0] mask_full;
    logic [DW-1:0]    m;

    assign mask_full = be2mask(8'(be), DW);
    assign m         = mask_full[DW-1:0];

    always_comb begin
        t = q;
        case (SwAccess)
            SW_RW, SW_WO: t = (wd & m) | (q & ~m);
            SW_W1S:       t = q | (wd & m);
            SW_W1C:       t = q & ~(wd & m);
            SW_W0C:       t = q & (wd | ~m);
            default:      t = q;
        endcase
    end

endmodule

// File: rtl/prim_subreg_shadow_be.sv
// rtl/prim_subreg_shadow_be.sv - shadowed byte-enabled subreg; storage check under PRIM_SUBREG_SHADOW_STORAGE_CHK_EN
module prim_subreg_shadow_be
    import prim_subreg_pkg::*;
#(
    parameter int            DW       = 32,
    parameter sw_access_e    SwAccess = SW_RW,
    parameter logic [DW-1:0] RESVAL   = '0,
    localparam int           BEW      = (DW + 7) / 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           we,
    input  logic [DW-1:0]  wd,
    input  logic [BEW-1:0] be,
    input  logic           re,
    input  logic           de,
    input  logic [DW-1:0]  d,
    output logic           qe,
    output logic [DW-1:0]  q,
    output logic [DW-1:0]  qs,
    output logic           phase,
    output logic           err_update,
    output logic           err_storage
);

    localparam bit SwWritable = (SwAccess != SW_RO);

    shadow_phase_e phase_q, phase_d;
    logic [DW-1:0] t;
    logic [DW-1:0] q_q, q_d;
    logic [DW-1:0] staged_q, staged_d;
    logic          stage, commit, mismatch;
    logic          qe_q, err_update_q;

    prim_subreg_sw_xform #(
        .DW       (DW),
        .SwAccess (SwAccess)
    ) u_xform (
        .q  (q_q),
        .wd (wd),
        .be (be),
        .t  (t)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= PH_IDLE;
        end else begin
            phase_q <= phase_d;
        end
    end

    // A write always toggles the phase; a read only matters while staged.
    always_comb begin
        phase_d = phase_q;
        if (SwWritable) begin
            if (we) begin
                phase_d = (phase_q == PH_IDLE) ? PH_STAGED : PH_IDLE;
            end else if (re && (phase_q == PH_STAGED)) begin
                phase_d = PH_IDLE;
            end
        end
    end

    always_comb begin
        stage    = SwWritable && we && (phase_q == PH_IDLE);
        commit   = SwWritable && we && (phase_q == PH_STAGED) && (t == staged_q);
        mismatch = SwWritable && we && (phase_q == PH_STAGED) && (t != staged_q);
    end

    // A committing software write overrides a same-cycle hardware write.
    assign q_d      = commit ? t : (de ? d : q_q);
    assign staged_d = stage ? t : staged_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q          <= RESVAL;
            staged_q     <= RESVAL;
            qe_q         <= 1'b0;
            err_update_q <= 1'b0;
        end else begin
            q_q          <= q_d;
            staged_q     <= staged_d;
            qe_q         <= commit;
            err_update_q <= mismatch;
        end
    end

`ifdef PRIM_SUBREG_SHADOW_STORAGE_CHK_EN
    logic [DW-1:0] shadow_q;
    logic          err_storage_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q      <= ~RESVAL;
            err_storage_q <= 1'b0;
        end else begin
            shadow_q <= ~q_d;
            if (shadow_q != ~q_q) begin
                err_storage_q <= 1'b1;
            end
        end
    end

    assign err_storage = err_storage_q;
`else
    assign err_storage = 1'b0;
`endif

    assign q          = q_q;
    assign qs         = q_q;
    assign qe         = qe_q;
    assign err_update = err_update_q;
    assign phase      = (phase_q == PH_STAGED);

endmodule
